// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rv32i_mem_arbiter
// Brief  : Single-port memory arbiter for RV32I fetch and load/store requests.
//          Define ARB_RR_EN for round-robin arbitration (default: data wins).
// Rev    : 1.0  initial release
// ============================================================================
module rv32i_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [3:0] c_be_word = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_D_BUSY  = 2'd2
  } state_t;

  state_t r_state;
  logic   w_grant_d;
  logic   w_grant_if;

`ifdef ARB_RR_EN
  // High when the fetch port received the most recent grant.
  logic   r_last_if;
  assign w_grant_d  = d_req & (~if_req | r_last_if);
`else
  assign w_grant_d  = d_req;
`endif
  assign w_grant_if = if_req & ~w_grant_d;

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
`ifdef ARB_RR_EN
      r_last_if <= 1'b1;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state   <= S_D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_be    <= d_we ? d_be : c_be_word;
            mem_wdata <= d_wdata;
`ifdef ARB_RR_EN
            r_last_if <= 1'b0;
`endif
          end else if (w_grant_if) begin
            r_state   <= S_IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_be    <= c_be_word;
            mem_wdata <= 32'h0;
`ifdef ARB_RR_EN
            r_last_if <= 1'b1;
`endif
          end
        end
        S_IF_BUSY: begin
          if (mem_ready) begin
            r_state  <= S_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end
        S_D_BUSY: begin
          if (mem_ready) begin
            r_state <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_done  <= 1'b1;
            // Stores leave the last load result in place.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_mem_arbiter
// Brief  : Scoreboard bench for rv32i_mem_arbiter with a memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall;

  rv32i_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  bit          grant_log[$];        // 1 = data access, 0 = fetch access
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] exp_d_rdata = 32'h0;

  int          mem_wait_fixed = -1;
  bit          force_ready = 1'b0;
  bit          in_acc = 1'b0;
  int          waits, acc_len, last_len;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory model: random or fixed wait states, protocol checks on the mem_* side.
  initial begin
    logic [31:0] cur;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        in_acc    = 1'b0;
      end else if (!mem_req) begin
        mem_ready = 1'b0;
        in_acc    = 1'b0;
      end else begin
        if (!in_acc) begin
          in_acc = 1'b1;
          snap_we = mem_we; snap_addr = mem_addr; snap_be = mem_be; snap_wdata = mem_wdata;
          acc_len = 0;
          waits = (mem_wait_fixed >= 0) ? mem_wait_fixed : int'($urandom_range(0, 3));
          grant_log.push_back(mem_addr >= 32'h1000);
          if (mem_addr < 32'h1000) begin
            check("fetch_mem_we", {31'h0, mem_we}, 32'h0);
            check("fetch_mem_be", {28'h0, mem_be}, 32'hF);
          end else if (!mem_we) begin
            check("load_mem_be", {28'h0, mem_be}, 32'hF);
          end
        end else begin
          check("hold_mem_we", {31'h0, mem_we}, {31'h0, snap_we});
          check("hold_mem_addr", mem_addr, snap_addr);
          check("hold_mem_be", {28'h0, mem_be}, {28'h0, snap_be});
          check("hold_mem_wdata", mem_wdata, snap_wdata);
        end
        acc_len++;
        if (waits == 0) begin
          mem_ready = 1'b1;
          cur = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
          if (mem_we) begin
            mem_arr[mem_addr] = merge(cur, mem_wdata, mem_be);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = cur;
          end
          last_len = acc_len;
          in_acc   = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          waits--;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a done pulse appears.
  initial begin
    forever begin
      @(negedge clk);
      check("stall", {31'h0, stall}, {31'h0, (if_req & ~if_done) | (d_req & ~d_done)});
      check("done_exclusive", {31'h0, if_done & d_done}, 32'h0);
      if (if_done) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_done_unexpected actual=1 required=0");
        end else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_done) begin
        if (d_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL d_done_unexpected actual=1 required=0");
        end else check("d_rdata", d_rdata, d_q.pop_front());
      end
    end
  end

  task automatic f_txn(input logic [31:0] addr, output int lat);
    int start;
    if_q.push_back(init_word(addr));
    if_req = 1'b1; if_addr = addr;
    start = cyc; lat = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (if_done) begin lat = cyc - start; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL if_timeout actual=none required=if_done");
    end
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int lat);
    int start;
    if (we) ref_mem[addr] = merge(ref_read(addr), wd, be);
    else    exp_d_rdata   = ref_read(addr);
    d_q.push_back(exp_d_rdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
    start = cyc; lat = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (d_done) begin lat = cyc - start; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL d_timeout actual=none required=d_done");
    end
  endtask

  task automatic d_agent(input int n, input bit gaps);
    int lat, g;
    for (int i = 0; i < n; i++) begin
      d_txn(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 7)),
            4'($urandom_range(0, 15)), $urandom, lat);
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      if (g > 0) begin d_req = 1'b0; repeat (g) @(negedge clk); end
    end
    d_req = 1'b0;
  endtask

  task automatic f_agent(input int n, input bit gaps);
    int lat, g;
    for (int i = 0; i < n; i++) begin
      f_txn({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, lat);
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      if (g > 0) begin if_req = 1'b0; repeat (g) @(negedge clk); end
    end
    if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, nd, ni;
    bit  last_d, pick_d;
    bit  exp_order[$];

    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_dones", {30'h0, if_done, d_done}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait fetch of address 4.
    mem_wait_fixed = 0;
    f_txn(32'h4, lat);
    if_req = 1'b0;
    check("fetch_latency", lat, 2);
    check("fetch_snap_we", {31'h0, snap_we}, 32'h0);
    repeat (2) @(negedge clk);

    // Load to give d_rdata a value, then a store with three wait states.
    d_txn(1'b0, 32'h2000, 4'h0, 32'h0, lat);
    d_req = 1'b0;
    @(negedge clk);
    mem_wait_fixed = 3;
    d_txn(1'b1, 32'h2000, 4'b0011, 32'hDEAD_BEEF, lat);
    d_req = 1'b0;
    check("store_latency", lat, 5);
    check("store_req_cycles", last_len, 4);
    check("store_snap_addr", snap_addr, 32'h2000);
    check("store_snap_we", {31'h0, snap_we}, 32'h1);
    check("store_snap_be", {28'h0, snap_be}, 32'h3);
    check("store_snap_wdata", snap_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_wait_fixed = 1;
    d_txn(1'b0, 32'h2000, 4'h0, 32'h0, lat);
    d_req = 1'b0;
    check("load_latency_1wait", lat, 3);
    @(negedge clk);

    // Reset in the middle of a stalled data access.
    mem_wait_fixed = 10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_be = 4'hF; d_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("abort_mem_req_before", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    d_req = 1'b0;
    exp_d_rdata = 32'h0;
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    check("abort_mem_we", {31'h0, mem_we}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_be", {28'h0, mem_be}, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    check("abort_if_rdata", if_rdata, 32'h0);
    check("abort_d_rdata", d_rdata, 32'h0);
    reset = 1'b1;
    force_ready = 1'b1;
    repeat (2) @(negedge clk);
    force_ready = 1'b0;
    check("late_ready_mem_req", {31'h0, mem_req}, 32'h0);
    repeat (2) @(negedge clk);

    // Contention with both ports holding requests back-to-back.
    mem_wait_fixed = -1;
    grant_log.delete();
    nd = 4; ni = 2;
    fork
      d_agent(nd, 1'b0);
      f_agent(ni, 1'b0);
    join
    last_d = 1'b0;
    while (nd > 0 || ni > 0) begin
      if (nd > 0 && ni > 0) begin
`ifdef ARB_RR_EN
        pick_d = !last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (nd > 0);
      end
      exp_order.push_back(pick_d);
      last_d = pick_d;
      if (pick_d) nd--; else ni--;
    end
    check("grant_count", grant_log.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      check($sformatf("grant_order[%0d]", i), {31'h0, grant_log[i]}, {31'h0, exp_order[i]});
    repeat (2) @(negedge clk);

    // Randomized traffic on both ports.
    fork
      d_agent(25, 1'b1);
      f_agent(25, 1'b1);
    join
    repeat (4) @(negedge clk);
    check("if_q_empty", if_q.size(), 0);
    check("d_q_empty", d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
